// File: rtl/daq_stream_pkg.sv
// Shared types and field widths for the burst framer: frame FSM states and
// the header layout {seq, len}.
package daq_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD,
        ST_TRAILER
    } frame_state_t;

    localparam int SEQ_W       = 8;
    localparam int LEN_W       = 8;
    localparam int TIMER_W     = 16;
    localparam int FRAME_CNT_W = 16;

    function automatic logic [SEQ_W+LEN_W-1:0] make_header(
        input logic [SEQ_W-1:0] seq,
        input logic [LEN_W-1:0] len
    );
        return {seq, len};
    endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single registered valid/ready output stage carrying data plus sof/last.
// Contents hold while valid is high and the sink is not ready.
module stream_out_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    input  logic         in_sof,
    input  logic         in_last,
    output logic         load,
    output logic         m_valid,
    output logic [W-1:0] m_data,
    output logic         m_sof,
    output logic         m_last,
    input  logic         m_ready
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;
    logic         sof_q, sof_d;
    logic         last_q, last_d;

    assign load = !valid_q || m_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sof_d   = sof_q;
        last_d  = last_q;
        if (load) begin
            valid_d = in_valid;
            sof_d   = in_valid && in_sof;
            last_d  = in_valid && in_last;
            // Data keeps its old value on an empty load; only valid matters then.
            if (in_valid) begin
                data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sof_q   <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sof_q   <= sof_d;
            last_q  <= last_d;
        end
    end

    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_sof   = sof_q;
    assign m_last  = last_q;

endmodule

// File: rtl/fifo_burst_framer.sv
// Drains a show-ahead FIFO into framed bursts: header {seq,len}, len payload
// words, XOR trailer. Partial frames are flushed after an idle timeout.
module fifo_burst_framer
    import daq_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COUNT_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [7:0]            burst_len,
    input  logic [15:0]           timeout_cycles,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_empty,
    input  logic [COUNT_WIDTH:0]  fifo_count,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_sof,
    output logic                  m_last,
    output logic                  busy,
    output logic [15:0]           frame_cnt,
    output logic                  flush_pulse
);

    frame_state_t           state_q, state_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       remain_q, remain_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [DATA_WIDTH-1:0]  checksum_q, checksum_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   flush_q, flush_d;

    logic [LEN_W-1:0]       eff_len;
    logic [COUNT_WIDTH:0]   eff_len_ext;
    logic [TIMER_W-1:0]     timer_inc;
    logic                   full_ready, partial_ready;
    logic                   load, pop;
    logic                   out_valid, out_sof, out_last;
    logic [DATA_WIDTH-1:0]  out_data;

    assign eff_len     = (burst_len == 8'd0) ? 8'd1 : burst_len;
    assign eff_len_ext = (COUNT_WIDTH+1)'(eff_len);
    assign timer_inc   = timer_q + 16'd1;

    assign full_ready    = en && (fifo_count >= eff_len_ext);
    assign partial_ready = en && (timeout_cycles != 16'd0) && (fifo_count != '0)
                           && (fifo_count < eff_len_ext);

    // Gated by rst so a reset arriving mid-payload never pops the FIFO.
    assign pop        = (state_q == ST_PAYLOAD) && load && !fifo_rd_empty && !rst;
    assign fifo_rd_en = pop;

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        len_d       = len_q;
        remain_d    = remain_q;
        timer_d     = timer_q;
        checksum_d  = checksum_q;
        frame_cnt_d = frame_cnt_q;
        flush_d     = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_sof     = 1'b0;
        out_last    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (full_ready) begin
                    state_d    = ST_HEADER;
                    len_d      = eff_len;
                    remain_d   = eff_len;
                    checksum_d = '0;
                    timer_d    = '0;
                end else if (partial_ready) begin
                    // >= guards against timeout_cycles being lowered mid-count.
                    if (timer_inc >= timeout_cycles) begin
                        state_d    = ST_HEADER;
                        len_d      = fifo_count[LEN_W-1:0];
                        remain_d   = fifo_count[LEN_W-1:0];
                        checksum_d = '0;
                        timer_d    = '0;
                        flush_d    = 1'b1;
                    end else begin
                        timer_d = timer_inc;
                    end
                end else begin
                    timer_d = '0;
                end
            end
            ST_HEADER: begin
                out_valid = 1'b1;
                out_sof   = 1'b1;
                out_data  = DATA_WIDTH'(make_header(seq_q, len_q));
                if (load) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                out_valid = !fifo_rd_empty;
                out_data  = fifo_rd_data;
                if (pop) begin
                    checksum_d = checksum_q ^ fifo_rd_data;
                    remain_d   = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        state_d = ST_TRAILER;
                    end
                end
            end
            ST_TRAILER: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_data  = checksum_q;
                if (load) begin
                    state_d     = ST_IDLE;
                    seq_d       = seq_q + 8'd1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            seq_q       <= '0;
            len_q       <= '0;
            remain_q    <= '0;
            timer_q     <= '0;
            checksum_q  <= '0;
            frame_cnt_q <= '0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            len_q       <= len_d;
            remain_q    <= remain_d;
            timer_q     <= timer_d;
            checksum_q  <= checksum_d;
            frame_cnt_q <= frame_cnt_d;
            flush_q     <= flush_d;
        end
    end

    stream_out_reg #(
        .W(DATA_WIDTH)
    ) u_out (
        .clk      (clk),
        .rst      (rst),
        .in_valid (out_valid),
        .in_data  (out_data),
        .in_sof   (out_sof),
        .in_last  (out_last),
        .load     (load),
        .m_valid  (m_valid),
        .m_data   (m_data),
        .m_sof    (m_sof),
        .m_last   (m_last),
        .m_ready  (m_ready)
    );

    assign busy        = (state_q != ST_IDLE);
    assign frame_cnt   = frame_cnt_q;
    assign flush_pulse = flush_q;

endmodule

// File: tb/tb_fifo_burst_framer.sv
// Directed bench for fifo_burst_framer: a show-ahead FIFO model feeds the DUT
// and a negedge monitor records every stream transfer for the scenario tasks.
module tb_fifo_burst_framer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  burst_len = 8'd0;
    logic [15:0] timeout_cycles = 16'd0;
    logic [15:0] fifo_rd_data;
    logic        fifo_rd_empty;
    logic [10:0] fifo_count;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_sof, m_last, busy, flush_pulse;
    logic [15:0] frame_cnt;

    int checks = 0;
    int failures = 0;

    fifo_burst_framer dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .burst_len      (burst_len),
        .timeout_cycles (timeout_cycles),
        .fifo_rd_data   (fifo_rd_data),
        .fifo_rd_empty  (fifo_rd_empty),
        .fifo_count     (fifo_count),
        .fifo_rd_en     (fifo_rd_en),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_sof          (m_sof),
        .m_last         (m_last),
        .busy           (busy),
        .frame_cnt      (frame_cnt),
        .flush_pulse    (flush_pulse)
    );

    // Show-ahead FIFO model
    logic [15:0] fifo_mem [0:2047];
    logic [10:0] wr_ptr = 11'd0;
    logic [10:0] rd_ptr = 11'd0;
    logic        fifo_clr = 1'b0;
    int          pops = 0;
    int          cyc = 0;

    assign fifo_count    = wr_ptr - rd_ptr;
    assign fifo_rd_empty = (wr_ptr == rd_ptr);
    assign fifo_rd_data  = fifo_mem[rd_ptr];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_clr) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en) begin
            rd_ptr <= rd_ptr + 11'd1;
            pops   <= pops + 1;
        end
    end

    // Transfer monitor
    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        last;
        int          cyc;
    } cap_t;
    cap_t cap[$];
    int   stall_err = 0;
    int   empty_pop_err = 0;
    logic pv = 1'b0, pr = 1'b1, ps = 1'b0, pl = 1'b0;
    logic [15:0] pd = 16'd0;

    always @(negedge clk) begin
        cap_t t;
        if (m_valid && m_ready) begin
            t.data = m_data; t.sof = m_sof; t.last = m_last; t.cyc = cyc;
            cap.push_back(t);
        end
        if (fifo_rd_en && fifo_rd_empty) empty_pop_err <= empty_pop_err + 1;
        if (!rst && pv && !pr &&
            (!m_valid || m_data !== pd || m_sof !== ps || m_last !== pl))
            stall_err <= stall_err + 1;
        pv <= m_valid; pr <= m_ready; pd <= m_data; ps <= m_sof; pl <= m_last;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [15:0] d);
        fifo_mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 11'd1;
    endtask

    task automatic do_reset();
        rst = 1'b1; fifo_clr = 1'b1; en = 1'b0; m_ready = 1'b1;
        tick(2);
        rst = 1'b0; fifo_clr = 1'b0;
        cap.delete();
        tick(1);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (frame_cnt != 16'(target) && n < budget) begin
            tick(1);
            n++;
        end
        tick(3);
        checks++;
        if (frame_cnt !== 16'(target)) begin
            failures++;
            $display("FAIL wait_frames timeout frame_cnt=%0d exp=%0d", frame_cnt, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        checks++;
        if ({m_valid, m_sof, m_last, busy, flush_pulse, fifo_rd_en} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000",
                     {m_valid, m_sof, m_last, busy, flush_pulse, fifo_rd_en});
        end
        checks++;
        if (m_data !== 16'h0000) begin
            failures++; $display("FAIL reset_m_data got=%h exp=0000", m_data);
        end
        checks++;
        if (frame_cnt !== 16'd0) begin
            failures++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt);
        end
    endtask

    task automatic test_full_frame();
        logic [15:0] exp [6] = '{16'h0004, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0004};
        logic [5:0]  sofs, lasts;
        do_reset();
        burst_len = 8'd4; timeout_cycles = 16'd0;
        for (int i = 1; i <= 4; i++) push(16'(i));
        en = 1'b1;
        wait_frames(1, 50);
        en = 1'b0;
        checks++;
        if (cap.size() !== 6) begin
            failures++; $display("FAIL full_size got=%0d exp=6", cap.size());
        end
        sofs = '0; lasts = '0;
        for (int i = 0; i < 6 && i < cap.size(); i++) begin
            sofs[i] = cap[i].sof; lasts[i] = cap[i].last;
            checks++;
            if (cap[i].data !== exp[i]) begin
                failures++; $display("FAIL full_word%0d got=%h exp=%h", i, cap[i].data, exp[i]);
            end
        end
        checks++;
        if ({lasts, sofs} !== {6'b100000, 6'b000001}) begin
            failures++; $display("FAIL full_markers got last=%b sof=%b exp last=100000 sof=000001", lasts, sofs);
        end
        checks++;
        if (cap.size() >= 6 && (cap[5].cyc - cap[0].cyc) !== 5) begin
            failures++; $display("FAIL full_frame_time got=%0d exp=5", cap[5].cyc - cap[0].cyc);
        end
    endtask

    task automatic test_timeout();
        int when = -1;
        int nflush = 0;
        do_reset();
        burst_len = 8'd8; timeout_cycles = 16'd10;
        push(16'h00A1); push(16'h00B2); push(16'h00C3);
        en = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick(1);
            if (flush_pulse === 1'b1) begin
                nflush++;
                if (when < 0) when = i;
            end
        end
        checks++;
        if (when !== 10) begin
            failures++; $display("FAIL timeout_flush_cycle got=%0d exp=10", when);
        end
        checks++;
        if (nflush !== 1) begin
            failures++; $display("FAIL timeout_pulse_width got=%0d exp=1", nflush);
        end
        wait_frames(1, 50);
        en = 1'b0;
        checks++;
        if (cap.size() !== 5) begin
            failures++; $display("FAIL timeout_size got=%0d exp=5", cap.size());
        end else begin
            checks++;
            if (cap[0].data !== 16'h0003 || cap[0].sof !== 1'b1) begin
                failures++; $display("FAIL timeout_header got=%h sof=%b exp=0003 sof=1", cap[0].data, cap[0].sof);
            end
            checks++;
            if (cap[4].data !== 16'h00D0 || cap[4].last !== 1'b1) begin
                failures++; $display("FAIL timeout_trailer got=%h last=%b exp=00d0 last=1", cap[4].data, cap[4].last);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] xs = 16'h0000;
        int p0, s0, e0, n;
        do_reset();
        burst_len = 8'd16; timeout_cycles = 16'd0;
        for (int i = 0; i < 16; i++) begin
            push(16'h1001 + 16'(i) * 16'h0101);
            xs ^= 16'h1001 + 16'(i) * 16'h0101;
        end
        p0 = pops; s0 = stall_err; e0 = empty_pop_err;
        en = 1'b1;
        n = 0;
        while (frame_cnt != 16'd1 && n < 200) begin
            tick(1); m_ready = ~m_ready; n++;
        end
        for (int i = 0; i < 6; i++) begin
            tick(1); m_ready = ~m_ready;
        end
        en = 1'b0; m_ready = 1'b1;
        tick(3);
        checks++;
        if (cap.size() !== 18) begin
            failures++; $display("FAIL bp_size got=%0d exp=18", cap.size());
        end else begin
            checks++;
            if (cap[0].data !== 16'h0010) begin
                failures++; $display("FAIL bp_header got=%h exp=0010", cap[0].data);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (cap[i+1].data !== 16'h1001 + 16'(i) * 16'h0101) begin
                    failures++; $display("FAIL bp_word%0d got=%h exp=%h", i, cap[i+1].data, 16'h1001 + 16'(i) * 16'h0101);
                end
            end
            checks++;
            if (cap[17].data !== xs || cap[17].last !== 1'b1) begin
                failures++; $display("FAIL bp_trailer got=%h exp=%h", cap[17].data, xs);
            end
        end
        checks++;
        if (pops - p0 !== 16) begin
            failures++; $display("FAIL bp_pops got=%0d exp=16", pops - p0);
        end
        checks++;
        if (stall_err - s0 !== 0) begin
            failures++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_err - s0);
        end
        checks++;
        if (empty_pop_err - e0 !== 0) begin
            failures++; $display("FAIL bp_pop_when_empty got=%0d exp=0", empty_pop_err - e0);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        burst_len = 8'd2; timeout_cycles = 16'd0;
        push(16'h0011); push(16'h0022); push(16'h0033); push(16'h0044);
        en = 1'b1;
        wait_frames(2, 60);
        en = 1'b0;
        checks++;
        if (cap.size() !== 8) begin
            failures++; $display("FAIL b2b_size got=%0d exp=8", cap.size());
        end else begin
            checks++;
            if (cap[4].data !== 16'h0102 || cap[4].sof !== 1'b1) begin
                failures++; $display("FAIL b2b_header2 got=%h exp=0102", cap[4].data);
            end
            checks++;
            if (cap[3].data !== 16'h0033 || cap[7].data !== 16'h0077) begin
                failures++; $display("FAIL b2b_trailers got=%h,%h exp=0033,0077", cap[3].data, cap[7].data);
            end
            checks++;
            if (cap[4].cyc - cap[0].cyc !== 5) begin
                failures++; $display("FAIL b2b_period got=%0d exp=5", cap[4].cyc - cap[0].cyc);
            end
        end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        burst_len = 8'd1; timeout_cycles = 16'd0;
        for (int i = 0; i < 257; i++) push(16'h2000 + 16'(i));
        en = 1'b1;
        wait_frames(257, 3000);
        en = 1'b0;
        checks++;
        if (cap.size() !== 771) begin
            failures++; $display("FAIL wrap_size got=%0d exp=771", cap.size());
        end else begin
            checks++;
            if (cap[765].data !== 16'hFF01) begin
                failures++; $display("FAIL wrap_header256 got=%h exp=ff01", cap[765].data);
            end
            checks++;
            if (cap[768].data !== 16'h0001) begin
                failures++; $display("FAIL wrap_header257 got=%h exp=0001", cap[768].data);
            end
            checks++;
            if (cap[769].data !== 16'h2100 || cap[770].data !== 16'h2100 || cap[770].last !== 1'b1) begin
                failures++; $display("FAIL wrap_len1_frame got=%h,%h exp=2100,2100", cap[769].data, cap[770].data);
            end
        end
        checks++;
        if (frame_cnt !== 16'd257) begin
            failures++; $display("FAIL wrap_frame_cnt got=%0d exp=257", frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int p0, n;
        int nlast = 0;
        do_reset();
        burst_len = 8'd4; timeout_cycles = 16'd0;
        push(16'h0A0A); push(16'h0B0B); push(16'h0C0C); push(16'h0D0D);
        p0 = pops;
        en = 1'b1;
        n = 0;
        while (pops - p0 < 2 && n < 30) begin
            tick(1); n++;
        end
        rst = 1'b1; en = 1'b0;
        #1;
        checks++;
        if (fifo_rd_en !== 1'b0) begin
            failures++; $display("FAIL rstmid_rd_en got=%b exp=0", fifo_rd_en);
        end
        tick(1);
        checks++;
        if ({m_valid, m_sof, m_last, busy, flush_pulse} !== 5'b0 || m_data !== 16'h0000) begin
            failures++; $display("FAIL rstmid_outputs got=%b data=%h exp=00000 data=0000",
                                 {m_valid, m_sof, m_last, busy, flush_pulse}, m_data);
        end
        checks++;
        if (pops - p0 !== 2) begin
            failures++; $display("FAIL rstmid_pops got=%0d exp=2", pops - p0);
        end
        rst = 1'b0;
        tick(10);
        foreach (cap[i]) if (cap[i].last) nlast++;
        checks++;
        if (nlast !== 0) begin
            failures++; $display("FAIL rstmid_trailer got=%0d exp=0", nlast);
        end
    endtask

    task automatic test_edge_cases();
        int p0, n;
        do_reset();
        burst_len = 8'd2; timeout_cycles = 16'd0;
        push(16'h0055); push(16'h0066);
        p0 = pops;
        tick(20);
        checks++;
        if (cap.size() !== 0 || pops - p0 !== 0 || frame_cnt !== 16'd0) begin
            failures++; $display("FAIL en_low got words=%0d pops=%0d frames=%0d exp=0,0,0",
                                 cap.size(), pops - p0, frame_cnt);
        end
        burst_len = 8'd0;
        en = 1'b1;
        wait_frames(2, 40);
        en = 1'b0;
        checks++;
        if (cap.size() !== 6) begin
            failures++; $display("FAIL len0_size got=%0d exp=6", cap.size());
        end else begin
            checks++;
            if (cap[0].data !== 16'h0001 || cap[2].data !== 16'h0055 || cap[3].data !== 16'h0101 || cap[5].data !== 16'h0066) begin
                failures++; $display("FAIL len0_words got=%h,%h,%h,%h exp=0001,0055,0101,0066",
                                     cap[0].data, cap[2].data, cap[3].data, cap[5].data);
            end
        end
        do_reset();
        burst_len = 8'd3;
        push(16'h0007); push(16'h0008); push(16'h0009);
        en = 1'b1;
        n = 0;
        while (!busy && n < 10) begin
            tick(1); n++;
        end
        en = 1'b0;
        wait_frames(1, 40);
        checks++;
        if (cap.size() !== 5 || cap[cap.size()-1].data !== 16'h0006) begin
            failures++; $display("FAIL en_drop_complete got words=%0d exp=5 trailer=0006", cap.size());
        end
        push(16'h0001); push(16'h0002); push(16'h0003);
        tick(20);
        checks++;
        if (frame_cnt !== 16'd1 || cap.size() !== 5) begin
            failures++; $display("FAIL en_drop_no_new got frames=%0d words=%0d exp=1,5", frame_cnt, cap.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_seq_wrap();
        test_reset_mid();
        test_edge_cases();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_burst_framer.md
FIFO_BURST_FRAMER -- requirements
Module: fifo_burst_framer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, FIFO word and stream width; only 16 is supported.
REQ-002 Parameter COUNT_WIDTH, default 10, width of fifo_count and of the producing FIFO's occupancy.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 en  input  1  framing enable; level-sensitive.
REQ-006 burst_len  input  8  payload words per full frame; 0 is treated as 1.
REQ-007 timeout_cycles  input  16  idle cycles before a partial flush; 0 disables timeout.
REQ-008 fifo_rd_data  input  DATA_WIDTH  show-ahead FIFO head word, valid while fifo_rd_empty=0.
REQ-009 fifo_rd_empty  input  1  FIFO empty.
REQ-010 fifo_count  input  COUNT_WIDTH+1  FIFO occupancy.
REQ-011 fifo_rd_en  output  1  pop strobe; head advances on the same edge.
REQ-012 m_data  output  16  stream word.
REQ-013 m_valid, m_ready  output, input  1 each  stream handshake; a transfer occurs when both are high.
REQ-014 m_sof, m_last  output  1 each  header-word and trailer-word markers.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 frame_cnt  output  16  frames completed, wraps.
REQ-017 flush_pulse  output  1  one-cycle pulse when a frame starts due to timeout.

Function
REQ-018 Frame format: header {seq[7:0], len[7:0]}, then len payload words in FIFO order, then trailer equal to the XOR of all payload words.
REQ-019 States: IDLE, HEADER, PAYLOAD, TRAILER, encoded as an enum.
REQ-020 IDLE->HEADER when en=1 and fifo_count >= eff_len, where eff_len = max(burst_len,1); len snapshots eff_len.
REQ-021 Timeout: in IDLE with en=1, timeout_cycles!=0 and 0 < fifo_count < eff_len, the timer increments each cycle.
REQ-022 On timer == timeout_cycles: go to HEADER with len = fifo_count[7:0], and assert flush_pulse for one cycle.
REQ-023 The timer clears in any other IDLE condition and on leaving IDLE; a full-frame start takes priority over timeout in the same cycle.
REQ-024 Output is a single registered stage; m_data, m_valid, m_sof and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-025 Load rule: the stage loads when (!m_valid || m_ready).
REQ-026 HEADER loads the header with m_sof=1, then moves to PAYLOAD.
REQ-027 PAYLOAD: fifo_rd_en = load && !fifo_rd_empty; each pop loads fifo_rd_data, XORs it into the checksum and decrements the remaining count; the word appears on m_data the cycle after the pop.
REQ-028 After the last payload pop, move to TRAILER; TRAILER loads the checksum with m_last=1.
REQ-029 TRAILER then returns to IDLE, with seq+1 (wraps 255->0) and frame_cnt+1 applied when the trailer is loaded.
REQ-030 fifo_rd_en SHALL never assert outside PAYLOAD or when fifo_rd_empty=1; a mid-frame empty FIFO stalls without emitting a word.
REQ-031 en deasserted mid-frame: the current frame completes, then no new frame starts.
REQ-032 Checksum clears on entry to HEADER.
REQ-033 A len=1 frame has a trailer equal to its single payload word.
REQ-034 Minimum frame time with m_ready=1 is len+2 cycles; back-to-back frames need one IDLE cycle between them.

Reset
REQ-035 While rst=1 at a clock edge, the following values are forced:
- state=IDLE, m_valid=0, m_sof=0, m_last=0, m_data=0;
- fifo_rd_en=0, busy=0, flush_pulse=0;
- frame_cnt=0, seq=0, timer=0, checksum=0.
REQ-036 Reset mid-frame abandons the frame: no trailer, and no FIFO pop in the reset cycle.

Structure
REQ-037 Package daq_stream_pkg holds the state enum and the header field widths.
REQ-038 The output register stage is sub-module stream_out_reg (data/sof/last plus valid/ready) and is instantiated once.

Verification
REQ-039 Full frame: burst_len=4; FIFO preloaded with 1,2,3,4; m_ready=1.
- Stream = 16'h0004, 1, 2, 3, 4, 16'h0004.
- m_sof on word 1, m_last on word 6, frame_cnt=1.
REQ-040 Timeout flush: burst_len=8, timeout_cycles=10, 3 words in the FIFO.
- flush_pulse asserts 10 cycles after the count stabilises.
- Header = 16'h0003.
REQ-041 Backpressure: m_ready toggled 1/0 every cycle during a 16-word frame.
- No word is lost or duplicated; m_data holds stable while stalled.
- Pop count = 16.
REQ-042 Sequence wrap: 257 frames of burst_len=1; frame 257 header = 16'h0001 (seq wrapped to 0); frame_cnt=257.
REQ-043 Reset mid-PAYLOAD after 2 of 4 pops: outputs return to reset values, with no trailer emitted.
REQ-044 Edge cases:
- burst_len=0 produces 1-word frames.
- en low produces no frames.
- en dropped mid-frame still completes that frame.
